// File: rtl/prgn_pkg.sv
// Shared definitions for the PRGN pipeline: checker state encoding and the
// xorshift32 step, so the generator and the checker agree bit-exactly.
package prgn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int XS_A = 13;
    localparam int XS_B = 17;
    localparam int XS_C = 5;

    localparam int NUM_PER_SEED_DEF = 256;

    // One xorshift32 step; bits shifted past either end are discarded.
    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << XS_A);
        y = y ^ (y >> XS_B);
        y = y ^ (y << XS_C);
        return y;
    endfunction

endpackage

// File: rtl/xorshift32_step.sv
// Combinational single xorshift32 step on the checker's expected-value path.
module xorshift32_step
    import prgn_pkg::*;
(
    input  logic [31:0] x,
    output logic [31:0] y
);

    assign y = xorshift32(x);

endmodule

// File: rtl/prgn_stream_checker.sv
// Receive-side checker: regenerates the xorshift32 sequence from an announced
// seed and scores the incoming stream, reporting pass/fail, first error, timeout, overrun.
module prgn_stream_checker
    import prgn_pkg::*;
#(
    parameter int NUM_PER_SEED = NUM_PER_SEED_DEF,
    parameter int TIMEOUT_CYC  = 4096,
    parameter int ERR_W        = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_valid,
    input  logic [31:0]      seed,
    input  logic             in_valid,
    input  logic [31:0]      rand_num,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       first_err_idx,
    output logic             timeout,
    output logic             overrun
);

    localparam int GAP_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       IDX_LAST = 8'(NUM_PER_SEED - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state;
    logic [31:0]      expected;
    logic [7:0]       idx;
    logic [GAP_W-1:0] gap;

    logic [31:0]      step_in;
    logic [31:0]      step_out;
    logic             mismatch;
    logic [ERR_W-1:0] err_next;

    // A new seed always wins the single step instance; otherwise advance expected.
    assign step_in  = seed_valid ? seed : expected;
    assign mismatch = (rand_num != expected);
    assign err_next = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + ERR_W'(1) : err_cnt;
    assign busy     = (state == CHECK);

    xorshift32_step u_step (
        .x (step_in),
        .y (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            expected      <= '0;
            idx           <= '0;
            gap           <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            timeout       <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (seed_valid) begin
                // Restart from any state; a coincident beat outside CHECK is
                // flagged after the clear so the overrun survives.
                state         <= CHECK;
                expected      <= step_out;
                idx           <= '0;
                gap           <= '0;
                pass          <= 1'b0;
                err_cnt       <= '0;
                first_err_idx <= '0;
                timeout       <= 1'b0;
                overrun       <= in_valid;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) overrun <= 1'b1;
                    end
                    CHECK: begin
                        if (in_valid) begin
                            err_cnt <= err_next;
                            if (mismatch && (err_cnt == '0)) first_err_idx <= idx;
                            expected <= step_out;
                            idx      <= idx + 8'd1;
                            gap      <= '0;
                            if (idx == IDX_LAST) begin
                                pass  <= (err_next == '0);
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end else if (gap == GAP_LAST) begin
                            timeout <= 1'b1;
                            pass    <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            gap <= gap + GAP_W'(1);
                        end
                    end
                    DONE: begin
                        if (in_valid) overrun <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prgn_stream_checker.sv
// Self-checking bench for prgn_stream_checker: drives seeded streams and
// compares each done-pulse result against a queue of expected outcomes.
module tb_prgn_stream_checker;

    localparam int N = 256;
    localparam int T = 4096;

    logic        clk;
    logic        rst_n;
    logic        seed_valid;
    logic [31:0] seed;
    logic        in_valid;
    logic [31:0] rand_num;
    logic        busy;
    logic        done;
    logic        pass;
    logic [8:0]  err_cnt;
    logic [7:0]  first_err_idx;
    logic        timeout;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    // {pass, timeout, overrun, first_err_idx[7:0], err_cnt[8:0]}
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;

    prgn_stream_checker #(.NUM_PER_SEED(N), .TIMEOUT_CYC(T), .ERR_W(9)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seed_valid    (seed_valid),
        .seed          (seed),
        .in_valid      (in_valid),
        .rand_num      (rand_num),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .timeout       (timeout),
        .overrun       (overrun)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] xs(input logic [31:0] v);
        logic [31:0] r;
        r = v ^ {v[18:0], 13'b0};
        r = r ^ {17'b0, r[31:17]};
        r = r ^ {r[26:0], 5'b0};
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_seed(input logic [31:0] s, input logic with_beat);
        seed_valid = 1'b1;
        seed       = s;
        in_valid   = with_beat;
        rand_num   = $urandom;
        @(posedge clk);
        #1;
        seed_valid = 1'b0;
        in_valid   = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] v);
        in_valid = 1'b1;
        rand_num = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_beats(input logic [31:0] s, input int n, input int c0, input int c1,
                             input int gap_max);
        logic [31:0] x;
        x = s;
        for (int k = 0; k < n; k++) begin
            x = xs(x);
            drive_beat((k == c0 || k == c1) ? (x ^ 32'h1) : x);
            if (gap_max > 0 && k < n - 1) idle(int'($urandom_range(0, gap_max)));
        end
    endtask

    task automatic push_exp(input logic p, input logic to, input logic ov,
                            input logic [7:0] fe, input logic [8:0] ec);
        exp_q.push_back({p, to, ov, fe, ec});
    endtask

    // Last beat was captured at the previous edge: done must show now, for one cycle.
    task automatic expect_done_next(input string tag);
        @(negedge clk);
        check_eq(tag, done, 1'b1);
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", done, 1'b0);
        check_eq("busy_after_done", busy, 1'b0);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_done", done, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("pass",          pass,          mon_e[19]);
                check_eq("timeout",       timeout,       mon_e[18]);
                check_eq("overrun",       overrun,       mon_e[17]);
                check_eq("first_err_idx", first_err_idx, mon_e[16:9]);
                check_eq("err_cnt",       err_cnt,       mon_e[8:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        rst_n      = 1'b0;
        seed_valid = 1'b0;
        seed       = '0;
        in_valid   = 1'b0;
        rand_num   = '0;

        #12;
        check_eq("rst_busy",    busy, 1'b0);
        check_eq("rst_done",    done, 1'b0);
        check_eq("rst_pass",    pass, 1'b0);
        check_eq("rst_err_cnt", err_cnt, 9'd0);
        check_eq("rst_overrun", overrun, 1'b0);
        check_eq("rst_timeout", timeout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Seed 1, clean stream.
        push_exp(1'b1, 1'b0, 1'b0, 8'd0, 9'd0);
        drive_seed(32'd1, 1'b0);
        check_eq("busy_in_check", busy, 1'b1);
        run_beats(32'd1, N, -1, -1, 0);
        expect_done_next("done_clean");

        // Beat 5 corrupted, then beats 5 and 200.
        push_exp(1'b0, 1'b0, 1'b0, 8'd5, 9'd1);
        drive_seed(32'd1, 1'b0);
        run_beats(32'd1, N, 5, -1, 0);
        expect_done_next("done_one_err");

        push_exp(1'b0, 1'b0, 1'b0, 8'd5, 9'd2);
        drive_seed(32'd1, 1'b0);
        run_beats(32'd1, N, 5, 200, 0);
        expect_done_next("done_two_err");

        // Stream stops after 100 beats -> gap timer aborts.
        push_exp(1'b0, 1'b1, 1'b0, 8'd0, 9'd0);
        drive_seed(32'h1234_5678, 1'b0);
        run_beats(32'h1234_5678, 100, -1, -1, 0);
        cyc = 0;
        while (cyc < T + 20) begin
            @(negedge clk);
            if (done) break;
            cyc++;
        end
        check_eq("timeout_latency", cyc, T);
        check_eq("timeout_busy_low", busy, 1'b0);
        check_eq("timeout_flag", timeout, 1'b1);
        @(posedge clk);
        #1;

        // Random gaps, no timeout expected.
        push_exp(1'b1, 1'b0, 1'b0, 8'd0, 9'd0);
        drive_seed(32'hDEAD_BEEF, 1'b0);
        run_beats(32'hDEAD_BEEF, N, -1, -1, 50);
        expect_done_next("done_gaps");

        // Stray beat in IDLE, then a fresh seed clears overrun.
        idle(2);
        drive_beat(32'hA5A5_A5A5);
        check_eq("overrun_idle", overrun, 1'b1);
        push_exp(1'b1, 1'b0, 1'b0, 8'd0, 9'd0);
        drive_seed(32'd1, 1'b0);
        check_eq("overrun_cleared", overrun, 1'b0);
        run_beats(32'd1, N, -1, -1, 0);
        expect_done_next("done_after_ovr");

        // Beat coincident with seed: overrun survives the clear.
        push_exp(1'b1, 1'b0, 1'b1, 8'd0, 9'd0);
        drive_seed(32'd1, 1'b1);
        run_beats(32'd1, N, -1, -1, 0);
        expect_done_next("done_coincident_ovr");

        // Re-seed with 7 after 50 beats of seed 1: only seed 7 reports.
        drive_seed(32'd1, 1'b0);
        run_beats(32'd1, 50, -1, -1, 0);
        push_exp(1'b1, 1'b0, 1'b0, 8'd0, 9'd0);
        drive_seed(32'd7, 1'b0);
        run_beats(32'd7, N, -1, -1, 0);
        expect_done_next("done_reseed");

        // Asynchronous reset in the middle of a sequence.
        drive_seed(32'd1, 1'b1);
        run_beats(32'd1, 30, 3, -1, 0);
        check_eq("pre_rst_err_cnt", err_cnt, 9'd1);
        check_eq("pre_rst_overrun", overrun, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy",     busy, 1'b0);
        check_eq("mid_rst_err_cnt",  err_cnt, 9'd0);
        check_eq("mid_rst_first",    first_err_idx, 8'd0);
        check_eq("mid_rst_overrun",  overrun, 1'b0);
        check_eq("mid_rst_state",    32'(dut.state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        push_exp(1'b1, 1'b0, 1'b0, 8'd0, 9'd0);
        drive_seed(32'd1, 1'b0);
        run_beats(32'd1, N, -1, -1, 0);
        expect_done_next("done_after_reset");

        idle(5);
        check_eq("exp_q_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
